// File: rtl/uv_decode_recon_if.sv
// Handshake and data bundle for the chroma reconstructor: request fields in, pixels and status out.
interface uv_decode_recon_if #(parameter int BLOCK_SIZE = 8);
    logic                          start;
    logic [9:0]                    x;
    logic [9:0]                    y;
    logic [1:0]                    mode_uv;
    logic [7:0]                    top_left_u;
    logic [7:0]                    top_left_v;
    logic [63:0]                   top_u;
    logic [63:0]                   top_v;
    logic [63:0]                   left_u;
    logic [63:0]                   left_v;
    logic [16*16*BLOCK_SIZE-1:0]   levels;
    logic [255:0]                  iq;
    logic [8*16*BLOCK_SIZE-1:0]    out;
    logic                          busy;
    logic                          done;

    modport master (
        output start, x, y, mode_uv, top_left_u, top_left_v,
        output top_u, top_v, left_u, left_v, levels, iq,
        input  out, busy, done
    );

    modport slave (
        input  start, x, y, mode_uv, top_left_u, top_left_v,
        input  top_u, top_v, left_u, left_v, levels, iq,
        output out, busy, done
    );
endinterface

// File: rtl/uv_decode_recon.sv
// Chroma macroblock reconstruction: DC/TM/V/H prediction plus 4x4 inverse transform over 8 U/V blocks.
// Latency 26 cycles from start to done; no backpressure, start is ignored unless idle.
module uv_decode_recon #(
    parameter int BLOCK_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst,
    uv_decode_recon_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PRED, DEQ, VERT, HORZ, DONE} state_t;

    localparam logic [2:0] LAST_BLK = 3'(BLOCK_SIZE - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [2:0]                    blk;
    logic [16*16*BLOCK_SIZE-1:0]   levels_q;
    logic [255:0]                  iq_q;
    logic [511:0]                  pred_u;
    logic [511:0]                  pred_v;
    logic signed [31:0]            coef [16];
    logic signed [31:0]            tmp  [16];
    logic signed [31:0]            coef_nxt [16];
    logic signed [31:0]            tmp_nxt  [16];
    logic [127:0]                  recon;
    logic [8*16*BLOCK_SIZE-1:0]    work;
    logic [8*16*BLOCK_SIZE-1:0]    out_q;

    function automatic logic [7:0] clip255(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic signed [31:0] m1(input logic signed [31:0] a);
        logic signed [31:0] p;
        p = a * 32'sd20091;
        return (p >>> 16) + a;
    endfunction

    function automatic logic signed [31:0] m2(input logic signed [31:0] a);
        logic signed [31:0] p;
        p = a * 32'sd35468;
        return p >>> 16;
    endfunction

    // Whole 8x8 prediction for one plane; pixel (r,c) lands at [8*(8r+c)+:8].
    function automatic logic [511:0] plane_pred(
        input logic [1:0]  mode,
        input logic [63:0] top,
        input logic [63:0] left,
        input logic [7:0]  tl,
        input logic        has_top,
        input logic        has_left
    );
        logic [511:0]       p;
        logic [12:0]        st;
        logic [12:0]        sl;
        logic [12:0]        acc;
        logic [7:0]         dc;
        logic signed [10:0] tm;
        p  = '0;
        st = '0;
        sl = '0;
        for (int k = 0; k < 8; k++) begin
            st = st + {5'd0, top[8*k +: 8]};
            sl = sl + {5'd0, left[8*k +: 8]};
        end
        if (has_top && has_left) begin
            acc = st + sl + 13'd8;
            dc  = acc[11:4];
        end else if (has_top) begin
            acc = st + 13'd4;
            dc  = acc[10:3];
        end else if (has_left) begin
            acc = sl + 13'd4;
            dc  = acc[10:3];
        end else begin
            acc = '0;
            dc  = 8'd128;
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                tm = $signed({3'b000, left[8*r +: 8]}) + $signed({3'b000, top[8*c +: 8]})
                   - $signed({3'b000, tl});
                case (mode)
                    2'd0: p[8*(8*r+c) +: 8] = dc;
                    2'd1: p[8*(8*r+c) +: 8] = (tm < 0) ? 8'd0 : (tm > 11'sd255) ? 8'd255 : tm[7:0];
                    2'd2: p[8*(8*r+c) +: 8] = top[8*c +: 8];
                    default: p[8*(8*r+c) +: 8] = left[8*r +: 8];
                endcase
            end
        end
        return p;
    endfunction

    always_comb begin : p_next
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = PRED;
            PRED:    state_nxt = DEQ;
            DEQ:     state_nxt = VERT;
            VERT:    state_nxt = HORZ;
            HORZ:    state_nxt = (blk == LAST_BLK) ? DONE : DEQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : p_dequant
        logic [15:0] lraw;
        lraw = '0;
        for (int i = 0; i < 16; i++) begin
            lraw        = levels_q[256*blk + 16*i +: 16];
            coef_nxt[i] = $signed({{16{lraw[15]}}, lraw}) * $signed({16'd0, iq_q[16*i +: 16]});
        end
    end

    // Column pass; result stored row-major so the row pass reads tmp[4i+j].
    always_comb begin : p_vert
        logic signed [31:0] ea, eb, ec, ed;
        ea = '0; eb = '0; ec = '0; ed = '0;
        for (int j = 0; j < 4; j++) begin
            ea = coef[j] + coef[8+j];
            eb = coef[j] - coef[8+j];
            ec = m2(coef[4+j]) - m1(coef[12+j]);
            ed = m1(coef[4+j]) + m2(coef[12+j]);
            tmp_nxt[j]    = ea + ed;
            tmp_nxt[4+j]  = eb + ec;
            tmp_nxt[8+j]  = eb - ec;
            tmp_nxt[12+j] = ea - ed;
        end
    end

    always_comb begin : p_horz
        logic signed [31:0] dcv, ea, eb, ec, ed;
        logic signed [31:0] v [4];
        logic [511:0]       pplane;
        logic [7:0]         pv;
        int                 row0;
        int                 col0;
        recon  = '0;
        dcv = '0; ea = '0; eb = '0; ec = '0; ed = '0;
        v[0] = '0; v[1] = '0; v[2] = '0; v[3] = '0;
        pv     = '0;
        pplane = blk[2] ? pred_v : pred_u;
        row0   = blk[1] ? 4 : 0;
        col0   = blk[0] ? 4 : 0;
        for (int i = 0; i < 4; i++) begin
            dcv  = tmp[4*i] + 32'sd4;
            ea   = dcv + tmp[4*i+2];
            eb   = dcv - tmp[4*i+2];
            ec   = m2(tmp[4*i+1]) - m1(tmp[4*i+3]);
            ed   = m1(tmp[4*i+1]) + m2(tmp[4*i+3]);
            v[0] = ea + ed;
            v[1] = eb + ec;
            v[2] = eb - ec;
            v[3] = ea - ed;
            for (int c = 0; c < 4; c++) begin
                pv = pplane[8*(8*(row0+i) + col0 + c) +: 8];
                recon[8*(4*i+c) +: 8] = clip255($signed({24'd0, pv}) + (v[c] >>> 3));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            blk      <= '0;
            levels_q <= '0;
            iq_q     <= '0;
            pred_u   <= '0;
            pred_v   <= '0;
            work     <= '0;
            out_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                coef[i] <= '0;
                tmp[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                PRED: begin
                    levels_q <= bus.levels;
                    iq_q     <= bus.iq;
                    pred_u   <= plane_pred(bus.mode_uv, bus.top_u, bus.left_u, bus.top_left_u,
                                           bus.y != 10'd0, bus.x != 10'd0);
                    pred_v   <= plane_pred(bus.mode_uv, bus.top_v, bus.left_v, bus.top_left_v,
                                           bus.y != 10'd0, bus.x != 10'd0);
                    blk      <= '0;
                end
                DEQ: begin
                    for (int i = 0; i < 16; i++) coef[i] <= coef_nxt[i];
                end
                VERT: begin
                    for (int i = 0; i < 16; i++) tmp[i] <= tmp_nxt[i];
                end
                HORZ: begin
                    work[128*blk +: 128] <= recon;
                    if (blk != LAST_BLK) blk <= blk + 3'd1;
                end
                DONE: out_q <= work;
                default: ;
            endcase
        end
    end

    // The finished buffer is visible during the done cycle itself, then held in out_q.
    assign bus.out  = (state == DONE) ? work : out_q;
    assign bus.done = (state == DONE);
    assign bus.busy = (state == PRED) || (state == DEQ) || (state == VERT) || (state == HORZ);

endmodule

// File: tb/tb_uv_decode_recon.sv
// Randomized and directed bench for uv_decode_recon against a plane/array reference model.
module tb_uv_decode_recon;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uv_decode_recon_if bus();
    uv_decode_recon dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit rst_edge = 1'b0;
    bit active   = 1'b0;
    int s_cyc    = 0;
    logic [1023:0] exp_cur = '0;
    logic [1023:0] exp_nxt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int b = 0; b < 8; b++) begin
                if (act[128*b +: 128] !== exp[128*b +: 128]) begin
                    $display("FAIL %s: block %0d got %h expected %h (cycle %0d)",
                             name, b, act[128*b +: 128], exp[128*b +: 128], cyc);
                    break;
                end
            end
        end
    endtask

    function automatic int clipi(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction
    function automatic int fm1(input int a);
        return ((a * 20091) >>> 16) + a;
    endfunction
    function automatic int fm2(input int a);
        return (a * 35468) >>> 16;
    endfunction

    // Reference: full-plane prediction, then dequant + 2-D inverse transform per block.
    function automatic logic [1023:0] model();
        logic [1023:0] res;
        int pr [2][8][8];
        int tp [8];
        int lf [8];
        int c [16];
        int t [4][4];
        int tl, st, sl, dc, pl, r0, c0, q0, q1, q2, q3, ea, eb, ec, ed;
        int v [4];
        res = '0;
        for (int p = 0; p < 2; p++) begin
            st = 0; sl = 0;
            for (int k = 0; k < 8; k++) begin
                tp[k] = (p == 0) ? int'(bus.top_u[8*k +: 8])  : int'(bus.top_v[8*k +: 8]);
                lf[k] = (p == 0) ? int'(bus.left_u[8*k +: 8]) : int'(bus.left_v[8*k +: 8]);
                st += tp[k];
                sl += lf[k];
            end
            tl = (p == 0) ? int'(bus.top_left_u) : int'(bus.top_left_v);
            if (bus.x > 0 && bus.y > 0) dc = (st + sl + 8) >> 4;
            else if (bus.y > 0)         dc = (st + 4) >> 3;
            else if (bus.x > 0)         dc = (sl + 4) >> 3;
            else                        dc = 128;
            for (int r = 0; r < 8; r++)
                for (int cc = 0; cc < 8; cc++)
                    case (bus.mode_uv)
                        2'd0: pr[p][r][cc] = dc;
                        2'd1: pr[p][r][cc] = clipi(lf[r] + tp[cc] - tl);
                        2'd2: pr[p][r][cc] = tp[cc];
                        default: pr[p][r][cc] = lf[r];
                    endcase
        end
        for (int b = 0; b < 8; b++) begin
            pl = b / 4;
            r0 = 4 * ((b % 4) / 2);
            c0 = 4 * (b % 2);
            for (int i = 0; i < 16; i++)
                c[i] = int'($signed(bus.levels[256*b + 16*i +: 16])) * int'(bus.iq[16*i +: 16]);
            for (int j = 0; j < 4; j++) begin
                ea = c[j] + c[8+j];
                eb = c[j] - c[8+j];
                ec = fm2(c[4+j]) - fm1(c[12+j]);
                ed = fm1(c[4+j]) + fm2(c[12+j]);
                t[j][0] = ea + ed; t[j][1] = eb + ec; t[j][2] = eb - ec; t[j][3] = ea - ed;
            end
            for (int i = 0; i < 4; i++) begin
                q0 = t[0][i]; q1 = t[1][i]; q2 = t[2][i]; q3 = t[3][i];
                ea = q0 + 4 + q2;
                eb = q0 + 4 - q2;
                ec = fm2(q1) - fm1(q3);
                ed = fm1(q1) + fm2(q3);
                v[0] = ea + ed; v[1] = eb + ec; v[2] = eb - ec; v[3] = ea - ed;
                for (int k = 0; k < 4; k++)
                    res[128*b + 8*(4*i+k) +: 8] = 8'(clipi(pr[pl][r0+i][c0+k] + (v[k] >>> 3)));
            end
        end
        return res;
    endfunction

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_edge = rst;
    end

    // Per-cycle compare of busy/done/out against the expected schedule.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_edge) begin
                active  = 1'b0;
                exp_cur = '0;
                chk("busy_rst", 32'(bus.busy), 0);
                chk("done_rst", 32'(bus.done), 0);
                chk_wide("out_rst", bus.out, '0);
            end else begin
                bit be, de;
                be = active && (cyc >= s_cyc + 1) && (cyc <= s_cyc + 25);
                de = active && (cyc == s_cyc + 26);
                chk("busy", 32'(bus.busy), 32'(be));
                chk("done", 32'(bus.done), 32'(de));
                chk_wide("out", bus.out, de ? exp_nxt : exp_cur);
                if (de) begin
                    exp_cur = exp_nxt;
                    active  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nb(input int tstep, input int lstep, input int tlv);
        for (int k = 0; k < 8; k++) begin
            bus.top_u[8*k +: 8]  = 8'(tstep * k);
            bus.top_v[8*k +: 8]  = 8'(tstep * k);
            bus.left_u[8*k +: 8] = 8'(lstep * k);
            bus.left_v[8*k +: 8] = 8'(lstep * k);
        end
        bus.top_left_u = 8'(tlv);
        bus.top_left_v = 8'(tlv);
    endtask

    task automatic set_top_const(input int val);
        bus.top_u = {8{8'(val)}};
        bus.top_v = {8{8'(val)}};
    endtask

    // Called just after a clock edge with the DUT idle; returns in cycle start+27.
    task automatic run(input bit poke);
        exp_nxt   = model();
        s_cyc     = cyc;
        active    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            bus.start = (poke && k == 5);
            tick();
        end
        bus.start = 1'b0;
        tick();
    endtask

    logic [1023:0] f;
    int rr, cc2, lv;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.mode_uv = '0;
        bus.levels = '0; bus.iq = '0;
        set_nb(0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Zero coefficients: output is the prediction.
        set_nb(10, 5, 20);
        bus.x = 10'd1; bus.y = 10'd1;
        for (int m = 0; m < 4; m++) begin
            bus.mode_uv = 2'(m);
            run(1'b0);
            if (m == 0) begin
                chk("dc_both_u", 32'(bus.out[7:0]), 26);
                chk("dc_both_v", 32'(bus.out[1023:1016]), 26);
            end
            if (m == 1) begin
                f = '0;
                for (int b = 0; b < 8; b++)
                    for (int i = 0; i < 16; i++) begin
                        rr  = 4 * ((b % 4) / 2) + i / 4;
                        cc2 = 4 * (b % 2) + i % 4;
                        f[128*b + 8*i +: 8] = 8'(clipi(5*rr + 10*cc2 - 20));
                    end
                chk_wide("tm_dut", bus.out, f);
                chk_wide("tm_model", model(), f);
            end
        end

        // DC edge availability.
        bus.mode_uv = 2'd0;
        bus.x = 10'd0; bus.y = 10'd0; run(1'b0);
        chk("dc_none", 32'(bus.out[7:0]), 128);
        bus.x = 10'd0; bus.y = 10'd3; run(1'b0);
        chk("dc_top", 32'(bus.out[7:0]), 35);
        bus.x = 10'd2; bus.y = 10'd0; run(1'b0);
        chk("dc_left", 32'(bus.out[1023:1016]), 18);

        // Single DC coefficient in block 0, vertical prediction from flat 128.
        bus.x = 10'd1; bus.y = 10'd1; bus.mode_uv = 2'd2;
        set_top_const(128);
        bus.levels = '0; bus.iq = '0;
        bus.levels[15:0] = 16'd1;
        bus.iq[15:0] = 16'd8;
        run(1'b1);
        f = {{112{8'd128}}, {16{8'd129}}};
        chk_wide("dc_only", bus.out, f);

        // Saturation in both directions.
        bus.iq[15:0] = 16'd16;
        for (int b = 0; b < 8; b++) bus.levels[256*b +: 16] = 16'd100;
        set_top_const(250);
        run(1'b0);
        f = {128{8'd255}};
        chk_wide("clip_hi", bus.out, f);
        for (int b = 0; b < 8; b++) bus.levels[256*b +: 16] = 16'hFF9C;
        set_top_const(5);
        run(1'b0);
        chk_wide("clip_lo", bus.out, '0);

        // Abort in flight: no done, outputs return to zero.
        bus.mode_uv = 2'd1; set_nb(9, 13, 40);
        exp_nxt = model(); s_cyc = cyc; active = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_out", 32'(bus.out[31:0]), 0);
        repeat (30) tick();

        // Randomized operations, back to back.
        for (int n = 0; n < 30; n++) begin
            bus.mode_uv = 2'($urandom_range(0, 3));
            bus.x = 10'($urandom_range(0, 2) * $urandom_range(0, 500));
            bus.y = 10'($urandom_range(0, 2) * $urandom_range(0, 500));
            bus.top_u = {$urandom, $urandom}; bus.top_v = {$urandom, $urandom};
            bus.left_u = {$urandom, $urandom}; bus.left_v = {$urandom, $urandom};
            bus.top_left_u = 8'($urandom); bus.top_left_v = 8'($urandom);
            for (int i = 0; i < 16; i++)
                bus.iq[16*i +: 16] = (n % 5 == 4) ? 16'($urandom) : 16'($urandom_range(1, 80));
            for (int i = 0; i < 128; i++) begin
                lv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) - 30 : 0;
                bus.levels[16*i +: 16] = (n % 5 == 4) ? 16'($urandom) : 16'(lv);
            end
            run(n % 4 == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
